// File: rtl/shift_unit_arbiter_pkg.sv
// Shared types and helpers for the shift unit arbiter.
// Option: SHIFT_UNIT_ARBITER_ROTATE_EN adds rotl().
package shift_unit_arbiter_pkg;

  // Helpers work on fixed maximum widths.
  // Callers zero-extend operands and truncate the result.
  localparam int MAXN = 16;
  localparam int MAXW = 64;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // First valid requester at or after ptr, wrapping modulo n.
  function automatic pick_t rr_pick(
    input logic [MAXN-1:0] valid,
    input logic [31:0]     ptr,
    input int              n
  );
    pick_t p;
    int    j;
    p = '0;
    for (int k = 0; k < MAXN; k++) begin
      j = (int'(ptr) + k) % n;
      if (k < n && !p.found && valid[j]) begin
        p.found = 1'b1;
        p.idx   = 4'(j);
      end
    end
    return p;
  endfunction

  function automatic logic [MAXW-1:0] wmask(
    input logic [31:0] w
  );
    logic [MAXW-1:0] one;
    one = 1;
    if (w >= 32'(MAXW)) return '1;
    return (one << w) - one;
  endfunction

  // Left shift within w bits.
  // Amounts of w or more clear the result.
  function automatic logic [MAXW-1:0] shl_sat(
    input logic [MAXW-1:0] data,
    input logic [MAXW-1:0] amt,
    input logic [31:0]     w
  );
    if (amt >= {32'd0, w}) return '0;
    return (data << amt) & wmask(w);
  endfunction

`ifdef SHIFT_UNIT_ARBITER_ROTATE_EN
  // Rotate left within w bits by amt mod w.
  function automatic logic [MAXW-1:0] rotl(
    input logic [MAXW-1:0] data,
    input logic [MAXW-1:0] amt,
    input logic [31:0]     w
  );
    logic [MAXW-1:0] a;
    logic [MAXW-1:0] d;
    logic [MAXW-1:0] wl;
    wl = {32'd0, w};
    a  = amt % wl;
    d  = data & wmask(w);
    return ((d << a) | (d >> (wl - a))) & wmask(w);
  endfunction
`endif

endpackage

// File: rtl/shift_unit_arbiter_if.sv
// Request/response bundle of the shift unit arbiter.
// Option: SHIFT_UNIT_ARBITER_ROTATE_EN adds req_rot/resp_rot.
interface shift_unit_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ*WIDTH-1:0] req_amt;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [WIDTH-1:0]      resp_data;
  logic [IDW-1:0]        resp_id;
`ifdef SHIFT_UNIT_ARBITER_ROTATE_EN
  logic [NREQ-1:0]       req_rot;
  logic                  resp_rot;
`endif

  // Arbiter side.
  modport slave (
    input  req_valid,
    input  req_data,
    input  req_amt,
    input  resp_ready,
`ifdef SHIFT_UNIT_ARBITER_ROTATE_EN
    input  req_rot,
    output resp_rot,
`endif
    output req_ready,
    output resp_valid,
    output resp_data,
    output resp_id
  );

  // Requesters plus consumer side.
  modport master (
    output req_valid,
    output req_data,
    output req_amt,
    output resp_ready,
`ifdef SHIFT_UNIT_ARBITER_ROTATE_EN
    output req_rot,
    input  resp_rot,
`endif
    input  req_ready,
    input  resp_valid,
    input  resp_data,
    input  resp_id
  );

endinterface

// File: rtl/shift_unit_rr_arbiter.sv
// Combinational round-robin picker.
// Search starts at ptr and wraps modulo NREQ.
module shift_unit_rr_arbiter
  import shift_unit_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_valid,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] gnt_idx,
  output logic                    found
);
  localparam int IDW = $clog2(NREQ);

  pick_t pick;
  logic  unused_idx;

  // Pick the winner and expand it to one-hot.
  always_comb begin
    pick    = rr_pick(MAXN'(req_valid),
                      32'(ptr), NREQ);
    found   = pick.found;
    gnt_idx = pick.idx[IDW-1:0];
    grant   = '0;
    if (pick.found)
      grant = NREQ'(1) << gnt_idx;
  end

  assign unused_idx = ^pick.idx;

endmodule

// File: rtl/shift_unit_arbiter.sv
// Round-robin shared left-shift unit, one result slot.
// Option: SHIFT_UNIT_ARBITER_ROTATE_EN enables rotate.
module shift_unit_arbiter
  import shift_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input logic              CLK,
  input logic              RESET,
  shift_unit_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_nxt;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gnt_idx;
  logic             found;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] op_data;
  logic [WIDTH-1:0] op_amt;
  logic [MAXW-1:0]  wide;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] resp_data_q;
  logic [IDW-1:0]   resp_id_q;
  logic             unused_wide;
`ifdef SHIFT_UNIT_ARBITER_ROTATE_EN
  logic             op_rot;
  logic             resp_rot_q;
`endif

  shift_unit_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req_valid (bus.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .gnt_idx   (gnt_idx),
    .found     (found)
  );

  // Accept while empty, or while full and draining.
  always_comb begin
    can_accept = (state == EMPTY) | bus.resp_ready;
    accept     = can_accept & found & ~RESET;
    bus.req_ready = accept ? grant : '0;
  end

  // Operand mux and the shared shifter.
  always_comb begin
    op_data = bus.req_data[gnt_idx*WIDTH +: WIDTH];
    op_amt  = bus.req_amt[gnt_idx*WIDTH +: WIDTH];
    wide    = shl_sat(MAXW'(op_data),
                      MAXW'(op_amt), 32'(WIDTH));
`ifdef SHIFT_UNIT_ARBITER_ROTATE_EN
    op_rot  = bus.req_rot[gnt_idx];
    if (op_rot)
      wide  = rotl(MAXW'(op_data),
                   MAXW'(op_amt), 32'(WIDTH));
`endif
    result  = wide[WIDTH-1:0];
  end

  assign unused_wide = ^wide;

  // Next state and next pointer.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    if (accept)
      ptr_nxt = (gnt_idx == IDW'(NREQ-1))
              ? '0 : gnt_idx + 1'b1;
    unique case (1'b1)
      accept:
        state_nxt = FULL;
      (state == FULL) && bus.resp_ready && !found:
        state_nxt = EMPTY;
      default: ;
    endcase
  end

  // State, pointer and result register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= EMPTY;
      ptr         <= '0;
      resp_data_q <= '0;
      resp_id_q   <= '0;
`ifdef SHIFT_UNIT_ARBITER_ROTATE_EN
      resp_rot_q  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (accept) begin
        resp_data_q <= result;
        resp_id_q   <= gnt_idx;
`ifdef SHIFT_UNIT_ARBITER_ROTATE_EN
        resp_rot_q  <= op_rot;
`endif
      end
    end
  end

  assign bus.resp_valid = (state == FULL);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
`ifdef SHIFT_UNIT_ARBITER_ROTATE_EN
  assign bus.resp_rot   = resp_rot_q;
`endif

endmodule
